df_tile_ptr_gen: RTL and testbench
==================================

Name: df_tile_ptr_gen

Overview:
- Parametrised successor to the fixed-width dataflow-controller tile pointer set.
- Walks the x/y/k/c tile loop nest from a loaded configuration (limits plus per-tensor steps).
- Emits one {psums, ifmaps, weights} tile offset triple per tile on a valid/ready stream to the DMA sequencer.
- All offsets are built incrementally from adders (no multipliers). Adds first/last reduction flags that the fixed struct set lacks.

Parameters:
- CNT_W, 12, width of each loop limit/index.
- ADR_W, 24, width of every step and every output offset.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle pulse; loads config, starts walk
- i_x_lim, i_y_lim, i_k_lim, i_c_lim  in  CNT_W each  last index (count-1) per loop
- i_ps_x_step, i_ps_y_step, i_ps_k_step  in  ADR_W each  psums steps
- i_if_x_step, i_if_y_step, i_if_c_step  in  ADR_W each  ifmaps steps
- i_wt_k_step, i_wt_c_step  in  ADR_W each  weights steps
- o_busy  out  1  walk in progress
- o_valid  out  1  pointer triple valid
- i_ready  in  1  consumer accepts
- o_ps_ptr, o_if_ptr, o_wt_ptr  out  ADR_W each  tile offsets
- o_first_c, o_last_c  out  1 each  c index == 0 / == c_lim for this tile
- o_last  out  1  final tile of the walk
- o_done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all indices and offsets 0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on i_start:
  - config is registered; indices and offsets are cleared.
  - o_valid=1 and o_busy=1 from the next cycle, presenting tile (0,0,0,0) with all pointers 0.
- RUN:
  - Outputs stay stable while o_valid && !i_ready.
  - On a handshake (o_valid && i_ready) the next tile is presented in the following cycle, so throughput is 1 tile/cycle.
- Loop order is x innermost, then y, then c, then k outermost. The c reduction sits inside k, so psums tiles repeat consecutively for each k.
- Index advance:
  - x increments; when x==x_lim it wraps to 0 and y increments.
  - y wraps to 0 and carries into c; c wraps to 0 and carries into k.
- Per-dimension offset registers:
  - Each loop index has an offset register per affected tensor.
  - The offset adds its step on increment and clears to 0 when its index wraps.
  - The next pointer is the registered sum of the dimension offsets:
    - ps = x*ps_x + y*ps_y + k*ps_k
    - if = x*if_x + y*if_y + c*if_c
    - wt = k*wt_k + c*wt_c
  - Sums are computed combinationally from next-state offsets and registered. Arithmetic is modulo 2^ADR_W; overflow is silently truncated.
- Flags:
  - o_last=1 when x,y,c,k all equal their limits.
  - o_first_c / o_last_c are derived from the presented c index.
- Final handshake (o_last) -> DONE:
  - o_valid=0; o_done=1 for exactly one cycle; o_busy=0 in that cycle.
  - DONE then returns to IDLE.
- All limits 0: exactly one tile is emitted with o_first_c=o_last_c=o_last=1.
- i_start while in RUN or DONE is ignored; the config registers are not disturbed.
- An i_ready held high while o_valid=0 has no effect.
- Reset asserted mid-walk returns the block to IDLE immediately, with all outputs 0. No o_done is emitted.

Optional Feature:
- Macro DF_PTR_LOOP_ORDER_EN.
- Defined:
  - Adds input port i_c_outer (1 bit), sampled at i_start.
  - When i_c_outer=1, the loop order is x, y, k, c (c outermost), for weight-stationary reuse.
  - Flags are still derived from the c index.
- Undefined: no port; the order is fixed at x, y, c, k.

Decomposition:
- Shared package df_ctrl_pkg:
  - Parametrised structs df_tile_cfg_t (limits plus steps) and df_tile_ptr_t (three pointers plus flags), parametrised via package localparams CNT_W/ADR_W defaults.
  - An FSM state enum.
- One natural sub-module, df_loop_cnt: a single loop level with index, limit, carry-in, carry-out and wrap. It is instantiated four times and chained by the selected order.

Test Plan:
- Single tile: all limits 0, steps 5, i_ready=1 -> one beat, pointers 0, o_first_c=o_last_c=o_last=1; o_done the cycle after the beat.
- Psums walk: x_lim=1, y_lim=1, c_lim=0, k_lim=1, ps_x=1, ps_y=16, ps_k=256, i_ready=1 -> o_ps_ptr sequence 0,1,16,17,256,257,272,273, then o_done.
- Reduction flags: x_lim=y_lim=k_lim=0, c_lim=2, if_c=100, wt_c=8 -> o_if_ptr 0,100,200; o_wt_ptr 0,8,16; first_c 1,0,0; last_c 0,0,1.
- Backpressure: 4-tile walk with i_ready toggling 1,0,0,1,... -> pointers held stable while stalled; exactly 4 beats; no duplicates or drops.
- Overflow and restart:
  - ADR_W=24, ps_x=0xFFFFFF, x_lim=1 -> second o_ps_ptr=0xFFFFFF.
  - i_start pulsed mid-walk -> ignored.
  - Reset mid-walk -> outputs 0, no o_done.
- DF_PTR_LOOP_ORDER_EN with i_c_outer=1: k_lim=1, c_lim=1, wt_k=1, wt_c=10 -> o_wt_ptr 0,1,10,11.

Source files
------------

// File: rtl/df_ctrl_pkg.sv
// df_ctrl_pkg: default widths, config/pointer structs and FSM state shared by the tile pointer generator.
package df_ctrl_pkg;
    localparam int CNT_W = 12;
    localparam int ADR_W = 24;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} df_state_t;

    typedef struct packed {
        logic [CNT_W-1:0] x_lim;
        logic [CNT_W-1:0] y_lim;
        logic [CNT_W-1:0] k_lim;
        logic [CNT_W-1:0] c_lim;
        logic [ADR_W-1:0] ps_x_step;
        logic [ADR_W-1:0] ps_y_step;
        logic [ADR_W-1:0] ps_k_step;
        logic [ADR_W-1:0] if_x_step;
        logic [ADR_W-1:0] if_y_step;
        logic [ADR_W-1:0] if_c_step;
        logic [ADR_W-1:0] wt_k_step;
        logic [ADR_W-1:0] wt_c_step;
    } df_tile_cfg_t;

    typedef struct packed {
        logic [ADR_W-1:0] ps_ptr;
        logic [ADR_W-1:0] if_ptr;
        logic [ADR_W-1:0] wt_ptr;
        logic             first_c;
        logic             last_c;
        logic             last;
    } df_tile_ptr_t;
endpackage

// File: rtl/df_loop_cnt.sv
// df_loop_cnt: one loop level -- index with limit/carry plus two per-tensor offset accumulators.
module df_loop_cnt #(
    parameter int CNT_W = 12,
    parameter int ADR_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clr,
    input  logic             i_cin,
    input  logic [CNT_W-1:0] i_lim,
    input  logic [ADR_W-1:0] i_step_a,
    input  logic [ADR_W-1:0] i_step_b,
    output logic [CNT_W-1:0] o_idx,
    output logic             o_wrap,
    output logic             o_cout,
    output logic [ADR_W-1:0] o_off_a_nxt,
    output logic [ADR_W-1:0] o_off_b_nxt
);
    logic [ADR_W-1:0] off_a, off_b;
    logic             zero;

    assign o_wrap      = o_idx == i_lim;
    assign o_cout      = i_cin && o_wrap;
    assign zero        = i_clr || o_cout;
    assign o_off_a_nxt = zero ? '0 : i_cin ? off_a + i_step_a : off_a;
    assign o_off_b_nxt = zero ? '0 : i_cin ? off_b + i_step_b : off_b;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_idx <= '0;
            off_a <= '0;
            off_b <= '0;
        end else begin
            o_idx <= zero ? '0 : i_cin ? o_idx + CNT_W'(1) : o_idx;
            off_a <= o_off_a_nxt;
            off_b <= o_off_b_nxt;
        end
    end
endmodule

// File: rtl/df_tile_ptr_gen.sv
// df_tile_ptr_gen: walks the x/y/c/k tile nest and streams {psums, ifmaps, weights} offsets.
// Define DF_PTR_LOOP_ORDER_EN to add i_c_outer, which makes c the outermost loop.
module df_tile_ptr_gen #(
    parameter int CNT_W = df_ctrl_pkg::CNT_W,
    parameter int ADR_W = df_ctrl_pkg::ADR_W
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
`ifdef DF_PTR_LOOP_ORDER_EN
    input  logic             i_c_outer,
`endif
    input  logic [CNT_W-1:0] i_x_lim,
    input  logic [CNT_W-1:0] i_y_lim,
    input  logic [CNT_W-1:0] i_k_lim,
    input  logic [CNT_W-1:0] i_c_lim,
    input  logic [ADR_W-1:0] i_ps_x_step,
    input  logic [ADR_W-1:0] i_ps_y_step,
    input  logic [ADR_W-1:0] i_ps_k_step,
    input  logic [ADR_W-1:0] i_if_x_step,
    input  logic [ADR_W-1:0] i_if_y_step,
    input  logic [ADR_W-1:0] i_if_c_step,
    input  logic [ADR_W-1:0] i_wt_k_step,
    input  logic [ADR_W-1:0] i_wt_c_step,
    output logic             o_busy,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ADR_W-1:0] o_ps_ptr,
    output logic [ADR_W-1:0] o_if_ptr,
    output logic [ADR_W-1:0] o_wt_ptr,
    output logic             o_first_c,
    output logic             o_last_c,
    output logic             o_last,
    output logic             o_done
);
    import df_ctrl_pkg::*;

    localparam int X = 0, Y = 1, C = 2, K = 3;

    df_state_t        state;
    logic [CNT_W-1:0] in_lim [4], cfg_lim [4], idx [4];
    logic [ADR_W-1:0] in_sa [4], in_sb [4], cfg_sa [4], cfg_sb [4], off_a [4], off_b [4];
    logic [3:0]       cin, cout, wrap;
    logic             c_outer, clr, adv, cy_x, cy_y, unused_ok;

    // Step slot a/b per level: x,y -> ps/if; c -> if/wt; k -> ps/wt.
    assign in_lim = '{i_x_lim, i_y_lim, i_c_lim, i_k_lim};
    assign in_sa  = '{i_ps_x_step, i_ps_y_step, i_if_c_step, i_ps_k_step};
    assign in_sb  = '{i_if_x_step, i_if_y_step, i_wt_c_step, i_wt_k_step};

    assign clr  = state == S_IDLE && i_start;
    assign adv  = o_valid && i_ready && !o_last;
    assign cy_x = adv && wrap[X];
    assign cy_y = cy_x && wrap[Y];
    // Carries are built from wrap flags only so the swappable c/k chain has no combinational loop.
    assign cin  = {c_outer ? cy_y : cy_y && wrap[C],
                   c_outer ? cy_y && wrap[K] : cy_y,
                   cy_x, adv};

    for (genvar i = 0; i < 4; i++) begin : g_lvl
        df_loop_cnt #(.CNT_W(CNT_W), .ADR_W(ADR_W)) u_cnt (
            .i_clk       (i_clk),
            .i_rstn      (i_rstn),
            .i_clr       (clr),
            .i_cin       (cin[i]),
            .i_lim       (cfg_lim[i]),
            .i_step_a    (cfg_sa[i]),
            .i_step_b    (cfg_sb[i]),
            .o_idx       (idx[i]),
            .o_wrap      (wrap[i]),
            .o_cout      (cout[i]),
            .o_off_a_nxt (off_a[i]),
            .o_off_b_nxt (off_b[i])
        );
    end

    assign o_last    = o_valid && &wrap;
    assign o_first_c = o_valid && idx[C] == '0;
    assign o_last_c  = o_valid && wrap[C];
    assign unused_ok = &{1'b0, cout, idx[X], idx[Y], idx[K]};

`ifndef DF_PTR_LOOP_ORDER_EN
    assign c_outer = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= S_IDLE;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_done   <= 1'b0;
            o_ps_ptr <= '0;
            o_if_ptr <= '0;
            o_wt_ptr <= '0;
            cfg_lim  <= '{default: '0};
            cfg_sa   <= '{default: '0};
            cfg_sb   <= '{default: '0};
`ifdef DF_PTR_LOOP_ORDER_EN
            c_outer  <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: if (i_start) begin
                    state    <= S_RUN;
                    o_busy   <= 1'b1;
                    o_valid  <= 1'b1;
                    o_ps_ptr <= '0;
                    o_if_ptr <= '0;
                    o_wt_ptr <= '0;
                    cfg_lim  <= in_lim;
                    cfg_sa   <= in_sa;
                    cfg_sb   <= in_sb;
`ifdef DF_PTR_LOOP_ORDER_EN
                    c_outer  <= i_c_outer;
`endif
                end
                S_RUN: if (o_valid && i_ready) begin
                    if (o_last) begin
                        state   <= S_DONE;
                        o_busy  <= 1'b0;
                        o_valid <= 1'b0;
                        o_done  <= 1'b1;
                    end else begin
                        o_ps_ptr <= off_a[X] + off_a[Y] + off_a[K];
                        o_if_ptr <= off_b[X] + off_b[Y] + off_a[C];
                        o_wt_ptr <= off_b[K] + off_b[C];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_df_tile_ptr_gen.sv
// tb_df_tile_ptr_gen: directed walks; expected beats queued at issue, checked by a negedge monitor.
module tb_df_tile_ptr_gen;
    localparam int CW = 12;
    localparam int AW = 24;
    localparam int TW = 3 * AW + 3;

    logic          clk = 1'b0, rstn = 1'b0, start = 1'b0, ready = 1'b0;
    logic [CW-1:0] x_lim, y_lim, k_lim, c_lim;
    logic [AW-1:0] ps_x, ps_y, ps_k, if_x, if_y, if_c, wt_k, wt_c;
    logic [AW-1:0] ps_ptr, if_ptr, wt_ptr;
    logic          busy, valid, first_c, last_c, last, done;
`ifdef DF_PTR_LOOP_ORDER_EN
    logic          c_outer = 1'b0;
`endif
    logic [TW-1:0] q [$];
    logic [TW-1:0] cur, prev, e;
    logic [3:0]    pat = 4'b1001;
    logic          stalled = 1'b0;
    int            tests = 0, fails = 0, cyc = 0, last_hs = -10, done_cnt = 0, d0;

    assign cur = {ps_ptr, if_ptr, wt_ptr, first_c, last_c, last};

    always #5 clk = ~clk;

    df_tile_ptr_gen #(.CNT_W(CW), .ADR_W(AW)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start),
`ifdef DF_PTR_LOOP_ORDER_EN
        .i_c_outer(c_outer),
`endif
        .i_x_lim(x_lim), .i_y_lim(y_lim), .i_k_lim(k_lim), .i_c_lim(c_lim),
        .i_ps_x_step(ps_x), .i_ps_y_step(ps_y), .i_ps_k_step(ps_k),
        .i_if_x_step(if_x), .i_if_y_step(if_y), .i_if_c_step(if_c),
        .i_wt_k_step(wt_k), .i_wt_c_step(wt_c),
        .o_busy(busy), .o_valid(valid), .i_ready(ready),
        .o_ps_ptr(ps_ptr), .o_if_ptr(if_ptr), .o_wt_ptr(wt_ptr),
        .o_first_c(first_c), .o_last_c(last_c), .o_last(last), .o_done(done)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (valid && stalled) begin
            tests++;
            if (cur !== prev) begin
                fails++;
                $display("FAIL stall_hold: got %h want %h", cur, prev);
            end
        end
        if (valid && ready) begin
            tests++;
            last_hs = cyc;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL extra_beat: got %h want none", cur);
            end else begin
                e = q.pop_front();
                if (cur !== e) begin
                    fails++;
                    $display("FAIL beat: got ps=%h if=%h wt=%h f/lc/l=%b%b%b want ps=%h if=%h wt=%h f/lc/l=%b",
                             ps_ptr, if_ptr, wt_ptr, first_c, last_c, last,
                             e[TW-1-:AW], e[TW-1-AW-:AW], e[TW-1-2*AW-:AW], e[2:0]);
                end
            end
        end
        if (done) begin
            tests++;
            done_cnt++;
            if (cyc != last_hs + 1 || busy || valid) begin
                fails++;
                $display("FAIL done_timing: got cyc=%0d busy=%b valid=%b want cyc=%0d busy=0 valid=0",
                         cyc, busy, valid, last_hs + 1);
            end
        end
        stalled = valid && !ready;
        prev = cur;
    end

    function automatic void exp(input int p, input int i, input int w, input bit f, input bit lc, input bit l);
        q.push_back({AW'(p), AW'(i), AW'(w), f, lc, l});
    endfunction

    task automatic walk(input int xl, input int yl, input int cl, input int kl,
                        input int px, input int py, input int pk,
                        input int ix, input int iy, input int ic,
                        input int wk, input int wc, input bit bp, input bit mid);
        d0 = done_cnt;
        x_lim = CW'(xl); y_lim = CW'(yl); c_lim = CW'(cl); k_lim = CW'(kl);
        ps_x = AW'(px); ps_y = AW'(py); ps_k = AW'(pk);
        if_x = AW'(ix); if_y = AW'(iy); if_c = AW'(ic);
        wt_k = AW'(wk); wt_c = AW'(wc);
        ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 200 && done_cnt == d0; k++) begin
            if (mid && k == 2) begin
                start = 1'b1;
                x_lim = CW'(5);
                ps_x  = AW'(1);
            end else start = 1'b0;
            ready = bp ? pat[k % 4] : 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (done_cnt != d0 + 1) begin
            fails++;
            $display("FAIL done_count: got %0d want %0d", done_cnt - d0, 1);
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_beats: got %0d left want 0", q.size());
        end
        q.delete();
    endtask

    initial begin
        {x_lim, y_lim, k_lim, c_lim} = '0;
        {ps_x, ps_y, ps_k, if_x, if_y, if_c, wt_k, wt_c} = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, valid, done, cur} !== '0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b valid=%b done=%b ptrs=%h want all 0", busy, valid, done, cur);
        end

        exp(0, 0, 0, 1, 1, 1);
        walk(0, 0, 0, 0, 5, 5, 5, 5, 5, 5, 5, 5, 0, 0);

        exp(0, 0, 0, 1, 1, 0);   exp(1, 0, 0, 1, 1, 0);   exp(16, 0, 0, 1, 1, 0);  exp(17, 0, 0, 1, 1, 0);
        exp(256, 0, 0, 1, 1, 0); exp(257, 0, 0, 1, 1, 0); exp(272, 0, 0, 1, 1, 0); exp(273, 0, 0, 1, 1, 1);
        walk(1, 1, 0, 1, 1, 16, 256, 0, 0, 0, 0, 0, 0, 0);

        exp(0, 0, 0, 1, 0, 0); exp(0, 100, 8, 0, 0, 0); exp(0, 200, 16, 0, 1, 1);
        walk(0, 0, 2, 0, 0, 0, 0, 0, 0, 100, 0, 8, 0, 0);

        exp(0, 0, 0, 1, 1, 0); exp(3, 7, 0, 1, 1, 0); exp(6, 14, 0, 1, 1, 0); exp(9, 21, 0, 1, 1, 1);
        walk(3, 0, 0, 0, 3, 0, 0, 7, 0, 0, 0, 0, 1, 0);

        // 0xFFFFFF + 1 wraps to 0 on the last tile; the mid-walk start must not disturb the config.
        exp(0, 0, 0, 1, 1, 0); exp(24'hFFFFFF, 0, 0, 1, 1, 0); exp(1, 0, 0, 1, 1, 0); exp(0, 0, 0, 1, 1, 1);
        walk(1, 1, 0, 0, 24'hFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 1);

`ifdef DF_PTR_LOOP_ORDER_EN
        c_outer = 1'b1;
        exp(0, 0, 0, 1, 0, 0); exp(0, 0, 1, 1, 0, 0); exp(0, 0, 10, 0, 1, 0); exp(0, 0, 11, 0, 1, 1);
        walk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0);
        c_outer = 1'b0;
`endif

        d0 = done_cnt;
        x_lim = CW'(10); y_lim = '0; c_lim = '0; k_lim = '0;
        ps_x = AW'(1);
        {ps_y, ps_k, if_x, if_y, if_c, wt_k, wt_c} = '0;
        ready = 1'b1;
        exp(0, 0, 0, 1, 1, 0); exp(1, 0, 0, 1, 1, 0); exp(2, 0, 0, 1, 1, 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        tests++;
        if ({busy, valid, done, cur} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got busy=%b valid=%b done=%b ptrs=%h want all 0", busy, valid, done, cur);
        end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (done_cnt != d0 || valid || q.size() != 0) begin
            fails++;
            $display("FAIL mid_reset_quiet: got done=%0d valid=%b left=%0d want 0 0 0", done_cnt - d0, valid, q.size());
        end
        q.delete();

        exp(0, 0, 0, 1, 1, 1);
        walk(0, 0, 0, 0, 5, 5, 5, 5, 5, 5, 5, 5, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
